// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared state encoding and control-word constants for the TSC pipeline hazard controller.
package pipeline_hazard_controller_pkg;

  typedef enum logic [1:0] {
    HZ_RUN      = 2'd0,
    HZ_MEM_WAIT = 2'd1,
    HZ_HALTED   = 2'd2,
    HZ_FAULT    = 2'd3
  } hz_state_e;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_write;
    logic idex_bubble;
    logic exmem_write;
    logic memwb_bubble;
  } hz_ctrl_t;

  localparam hz_ctrl_t CTRL_RUN     = 7'b1101010;
  localparam hz_ctrl_t CTRL_DRAIN   = 7'b0010101;  // reset and HLT retire
  localparam hz_ctrl_t CTRL_FREEZE  = 7'b0000001;  // memory wait, HALTED, FAULT
  localparam hz_ctrl_t CTRL_BRANCH  = 7'b1111110;
  localparam hz_ctrl_t CTRL_LOADUSE = 7'b0001110;
  localparam hz_ctrl_t CTRL_JUMP    = 7'b1111010;

  // Advancing-pipeline decode: branch beats load-use beats jump.
  function automatic hz_ctrl_t hz_advance(input logic branch, input logic load_use,
                                          input logic jump);
    hz_ctrl_t c;
    if (branch)        c = CTRL_BRANCH;
    else if (load_use) c = CTRL_LOADUSE;
    else if (jump)     c = CTRL_JUMP;
    else               c = CTRL_RUN;
    return c;
  endfunction

endpackage

// File: rtl/pipeline_hazard_controller_load_use.sv
// Load-use detector: ID source operands against the destination of a load sitting in EX.
module load_use_detector #(
  parameter int REG_ADDR_W = 2
) (
  input  logic                  id_rs_used,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic                  id_rt_used,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  ex_mem_read,
  input  logic                  ex_reg_write,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  load_use
);

  assign load_use = ex_mem_read & ex_reg_write &
                    ((id_rs_used & (id_rs == ex_rd)) | (id_rt_used & (id_rt == ex_rd)));

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage TSC pipeline; RUN/MEM_WAIT/HALTED/FAULT FSM.
// Optional perf counters are built only when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_controller
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int REG_ADDR_W  = 2,
  parameter int WAIT_CNT_W  = 4,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_rs_used,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic                  id_rt_used,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_jump,
  input  logic                  ex_mem_read,
  input  logic                  ex_reg_write,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_branch_taken,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  input  logic                  wb_halt,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  ifid_flush,
  output logic                  idex_write,
  output logic                  idex_bubble,
  output logic                  exmem_write,
  output logic                  memwb_bubble,
  output logic                  halted,
  output logic                  fault,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_count
);

  hz_state_e             state_q, state_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  hz_ctrl_t              ctrl;
  logic                  load_use;

  load_use_detector #(.REG_ADDR_W(REG_ADDR_W)) u_load_use (
    .id_rs_used  (id_rs_used),
    .id_rs       (id_rs),
    .id_rt_used  (id_rt_used),
    .id_rt       (id_rt),
    .ex_mem_read (ex_mem_read),
    .ex_reg_write(ex_reg_write),
    .ex_rd       (ex_rd),
    .load_use    (load_use)
  );

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    ctrl       = CTRL_FREEZE;
    case (state_q)
      HZ_RUN: begin
        if (wb_halt) begin
          ctrl    = CTRL_DRAIN;
          state_d = HZ_HALTED;
        end else if (mem_req & ~mem_ready) begin
          ctrl       = CTRL_FREEZE;
          state_d    = HZ_MEM_WAIT;
          wait_cnt_d = WAIT_CNT_W'(1);
        end else begin
          ctrl = hz_advance(ex_branch_taken, load_use, id_jump);
        end
      end
      HZ_MEM_WAIT: begin
        if (mem_ready) begin
          ctrl       = hz_advance(ex_branch_taken, load_use, id_jump);
          state_d    = HZ_RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_CNT_W'(MEM_TIMEOUT)) begin
          state_d = HZ_FAULT;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: ctrl = CTRL_FREEZE;
    endcase
    // Reset is seen combinationally so the pipeline drains while it is held.
    if (reset) ctrl = CTRL_DRAIN;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= HZ_RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign pc_write     = ctrl.pc_write;
  assign ifid_write   = ctrl.ifid_write;
  assign ifid_flush   = ctrl.ifid_flush;
  assign idex_write   = ctrl.idex_write;
  assign idex_bubble  = ctrl.idex_bubble;
  assign exmem_write  = ctrl.exmem_write;
  assign memwb_bubble = ctrl.memwb_bubble;
  assign halted       = (state_q == HZ_HALTED);
  assign fault        = (state_q == HZ_FAULT);

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, flush_q;
  logic             active;

  assign active = (state_q == HZ_RUN) | (state_q == HZ_MEM_WAIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (active & ~ctrl.pc_write & ~&stall_q) stall_q <= stall_q + 1'b1;
      if (active & ctrl.ifid_flush & ~&flush_q) flush_q <= flush_q + 1'b1;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench for pipeline_hazard_controller: stimulus pushes expected control words,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_pipeline_hazard_controller;
  localparam int RW    = 2;
  localparam int CNT_W = 16;

  // {pc_w, ifid_w, ifid_flush, idex_w, idex_bubble, exmem_w, memwb_bubble, halted, fault}
  localparam logic [8:0] E_RST    = 9'b001010100;
  localparam logic [8:0] E_RUN    = 9'b110101000;
  localparam logic [8:0] E_LU     = 9'b000111000;
  localparam logic [8:0] E_BR     = 9'b111111000;
  localparam logic [8:0] E_JMP    = 9'b111101000;
  localparam logic [8:0] E_FRZ    = 9'b000000100;
  localparam logic [8:0] E_HALTED = 9'b000000110;
  localparam logic [8:0] E_FAULT  = 9'b000000101;

  logic clk = 1'b0;
  logic reset;
  logic id_rs_used, id_rt_used, id_jump, ex_mem_read, ex_reg_write, ex_branch_taken;
  logic mem_req, mem_ready, wb_halt;
  logic [RW-1:0] id_rs, id_rt, ex_rd;
  logic pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write, memwb_bubble;
  logic halted, fault;
  logic [CNT_W-1:0] stall_cycles, flush_count;

  typedef struct {
    logic [8:0] exp;
    logic       rst;
    string      name;
  } item_t;

  item_t sb[$];
  int tests = 0;
  int fails = 0;
  logic [CNT_W-1:0] m_stall = '0, m_flush = '0;

  always #5 clk = ~clk;

  pipeline_hazard_controller #(.REG_ADDR_W(RW), .WAIT_CNT_W(4), .MEM_TIMEOUT(15), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .id_rs_used(id_rs_used), .id_rs(id_rs), .id_rt_used(id_rt_used), .id_rt(id_rt),
    .id_jump(id_jump), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .ex_rd(ex_rd),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .wb_halt(wb_halt),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_write(idex_write), .idex_bubble(idex_bubble), .exmem_write(exmem_write),
    .memwb_bubble(memwb_bubble), .halted(halted), .fault(fault),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  // Monitor: outputs are valid every cycle, so each queued expectation is checked mid-cycle.
  always @(negedge clk) begin
    item_t it;
    logic [8:0] act;
    if (sb.size() > 0) begin
      it  = sb.pop_front();
      act = {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write,
             memwb_bubble, halted, fault};
      if (it.rst) begin
        m_stall = '0;
        m_flush = '0;
      end
      tests++;
      if (act !== it.exp || stall_cycles !== m_stall || flush_count !== m_flush) begin
        fails++;
        $display("FAIL %s: got ctrl=%b stall=%0d flush=%0d, want ctrl=%b stall=%0d flush=%0d",
                 it.name, act, stall_cycles, flush_count, it.exp, m_stall, m_flush);
      end
`ifdef HAZARD_PERF_CNT_EN
      if (!it.rst && !it.exp[1] && !it.exp[0]) begin
        if (!it.exp[8] && m_stall != '1) m_stall = m_stall + 1'b1;
        if (it.exp[6] && m_flush != '1) m_flush = m_flush + 1'b1;
      end
`endif
    end
  end

  task automatic quiet();
    id_rs_used = 0; id_rs = 0; id_rt_used = 0; id_rt = 0; id_jump = 0;
    ex_mem_read = 0; ex_reg_write = 0; ex_rd = 0; ex_branch_taken = 0;
    mem_req = 0; mem_ready = 0; wb_halt = 0;
  endtask

  // Inputs are already applied; queue the expectation and advance one cycle.
  task automatic step(input logic [8:0] exp, input string name);
    item_t it;
    it.exp = exp; it.rst = reset; it.name = name;
    sb.push_back(it);
    @(posedge clk); #1;
  endtask

  task automatic load_hazard(input logic [RW-1:0] rd);
    ex_mem_read = 1; ex_reg_write = 1; ex_rd = rd;
  endtask

  initial begin
    reset = 1; quiet();
    @(posedge clk); #1;

    // 1. reset held 3 cycles, then quiet run
    for (int i = 0; i < 3; i++) step(E_RST, "reset_hold");
    reset = 0;
    step(E_RUN, "run_after_reset");
    step(E_RUN, "run_quiet");

    // 2. load-use on rs, rt, then no match / gating
    load_hazard(2); id_rs_used = 1; id_rs = 2;
    step(E_LU, "loaduse_rs");
    quiet(); step(E_RUN, "loaduse_released");
    load_hazard(2); id_rs_used = 1; id_rs = 1;
    step(E_RUN, "loaduse_rs_nomatch");
    load_hazard(3); id_rt_used = 1; id_rt = 3;
    step(E_LU, "loaduse_rt");
    load_hazard(3); id_rt_used = 0; id_rt = 3;
    step(E_RUN, "loaduse_rt_unused");
    load_hazard(1); ex_reg_write = 0; id_rs_used = 1; id_rs = 1;
    step(E_RUN, "loaduse_no_regwrite");
    quiet();

    // 3. branch overrides load-use and jump; jump waits out load-use stall
    load_hazard(1); id_rs_used = 1; id_rs = 1; id_jump = 1; ex_branch_taken = 1;
    step(E_BR, "branch_over_all");
    ex_branch_taken = 0;
    step(E_LU, "loaduse_over_jump");
    quiet(); id_jump = 1;
    step(E_JMP, "jump_after_stall");
    quiet();

    // 4. memory wait of 3 cycles; branch ignored while frozen
    mem_req = 1; mem_ready = 0;
    step(E_FRZ, "freeze_1");
    ex_branch_taken = 1; id_jump = 1;
    step(E_FRZ, "freeze_2_branch_ignored");
    ex_branch_taken = 0; id_jump = 0;
    step(E_FRZ, "freeze_3");
    mem_ready = 1;
    step(E_RUN, "mem_ready_advance");
    quiet(); step(E_RUN, "back_in_run");

    // memory wait ending with branch / load-use evaluated on the ready cycle
    mem_req = 1;
    step(E_FRZ, "freeze_b1");
    mem_ready = 1; ex_branch_taken = 1;
    step(E_BR, "ready_with_branch");
    quiet(); mem_req = 1;
    step(E_FRZ, "freeze_l1");
    mem_ready = 1; load_hazard(0); id_rt_used = 1; id_rt = 0;
    step(E_LU, "ready_with_loaduse");
    quiet();

    // 5. timeout: 16 not-ready cycles, then sticky FAULT until reset
    mem_req = 1;
    for (int i = 0; i < 16; i++) step(E_FRZ, "timeout_freeze");
    step(E_FAULT, "fault_entered");
    mem_ready = 1; wb_halt = 1;
    step(E_FAULT, "fault_sticky");
    quiet(); reset = 1;
    step(E_RST, "fault_reset");
    reset = 0;
    step(E_RUN, "run_after_fault");

    // reset in the middle of a memory wait
    mem_req = 1;
    step(E_FRZ, "midwait_1");
    step(E_FRZ, "midwait_2");
    reset = 1;
    step(E_RST, "midwait_reset");
    reset = 0; quiet();
    step(E_RUN, "run_after_midwait");

    // 6. HLT retires (and beats a memory freeze); sticky until reset
    wb_halt = 1; mem_req = 1;
    step(E_RST, "halt_retire");
    quiet();
    for (int i = 0; i < 3; i++) step(E_HALTED, "halted_sticky");
    id_jump = 1; ex_branch_taken = 1;
    step(E_HALTED, "halted_ignores_inputs");
    quiet(); reset = 1;
    step(E_RST, "halt_reset");
    reset = 0;
    step(E_RUN, "run_after_halt");

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      tests++; fails++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
